// File: rtl/bp_if.sv
// Fetch-side prediction and execute-side resolution signals of the next-PC unit.
// The core-side logic uses the master modport and the predictor uses the slave modport.
interface bp_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_fetch_pc;
    logic             o_pred_taken;
    logic [WIDTH-1:0] o_pred_target;
    logic             i_clear;
    logic             i_res_valid;
    logic             i_res_is_jump;
    logic             i_res_is_jalr;
    logic             i_res_cond;
    logic [WIDTH-1:0] i_res_pc;
    logic [WIDTH-1:0] i_res_offset;
    logic [WIDTH-1:0] i_res_rs1;
    logic             i_res_pred_taken;
    logic [WIDTH-1:0] i_res_pred_target;
    logic             o_mispredict;
    logic [WIDTH-1:0] o_redirect_pc;
    logic [31:0]      o_br_count;
    logic [31:0]      o_mp_count;

    modport master (
        output i_fetch_pc, i_clear, i_res_valid, i_res_is_jump, i_res_is_jalr, i_res_cond,
               i_res_pc, i_res_offset, i_res_rs1, i_res_pred_taken, i_res_pred_target,
        input  o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc, o_br_count, o_mp_count
    );

    modport slave (
        input  i_fetch_pc, i_clear, i_res_valid, i_res_is_jump, i_res_is_jalr, i_res_cond,
               i_res_pc, i_res_offset, i_res_rs1, i_res_pred_taken, i_res_pred_target,
        output o_pred_taken, o_pred_target, o_mispredict, o_redirect_pc, o_br_count, o_mp_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch prediction, execute-stage
// target resolution with misprediction flagging, table training and saturating perf counters.
module branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    bp_if.slave  bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [WIDTH-1:0]   target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        br_count_q, br_count_d;
    logic [31:0]        mp_count_q, mp_count_d;

    logic [IDX-1:0]   f_idx_s, r_idx_s;
    logic [TAGW-1:0]  f_tag_s, r_tag_s;
    logic             f_hit_s, r_hit_s;
    logic             taken_s, mispredict_s;
    logic [WIDTH-1:0] tgt_s, jalr_sum_s;
    logic             ent_we_s;
    logic [WIDTH-1:0] ent_target_d;
    logic [1:0]       ent_ctr_d;

    assign f_idx_s = bus.i_fetch_pc[IDX+1:2];
    assign f_tag_s = bus.i_fetch_pc[WIDTH-1:IDX+2];
    assign r_idx_s = bus.i_res_pc[IDX+1:2];
    assign r_tag_s = bus.i_res_pc[WIDTH-1:IDX+2];
    assign f_hit_s = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    assign r_hit_s = valid_q[r_idx_s] && (tag_q[r_idx_s] == r_tag_s);

    // Fetch-side lookup: no bypass, so a same-cycle update is not visible here
    always_comb begin
        bus.o_pred_taken  = f_hit_s && ctr_q[f_idx_s][1];
        if (bus.o_pred_taken) begin
            bus.o_pred_target = target_q[f_idx_s];
        end else begin
            bus.o_pred_target = bus.i_fetch_pc + {{(WIDTH-3){1'b0}}, 3'd4};
        end
    end

    // Execute-side target resolution and misprediction detection
    always_comb begin
        taken_s    = bus.i_res_is_jump | bus.i_res_cond;
        jalr_sum_s = bus.i_res_rs1 + bus.i_res_offset;
        if (bus.i_res_is_jalr) begin
            tgt_s = jalr_sum_s & {{(WIDTH-1){1'b1}}, 1'b0};
        end else begin
            tgt_s = bus.i_res_pc + bus.i_res_offset;
        end
        if (taken_s) begin
            bus.o_redirect_pc = tgt_s;
        end else begin
            bus.o_redirect_pc = bus.i_res_pc + {{(WIDTH-3){1'b0}}, 3'd4};
        end
        mispredict_s = i_rst_n && bus.i_res_valid &&
                       ((bus.i_res_pred_taken != taken_s) ||
                        (taken_s && (bus.i_res_pred_target != tgt_s)));
        bus.o_mispredict = mispredict_s;
    end

    // Next-state of the entry addressed by the resolving PC
    always_comb begin
        ent_we_s     = 1'b0;
        ent_target_d = target_q[r_idx_s];
        ent_ctr_d    = ctr_q[r_idx_s];
        if (bus.i_res_valid && !bus.i_clear) begin
            if (taken_s) begin
                ent_we_s     = 1'b1;
                ent_target_d = tgt_s;
                if (bus.i_res_is_jump) begin
                    ent_ctr_d = 2'd3;
                end else if (!r_hit_s) begin
                    ent_ctr_d = 2'd2;
                end else if (ctr_q[r_idx_s] == 2'd3) begin
                    ent_ctr_d = 2'd3;
                end else begin
                    ent_ctr_d = ctr_q[r_idx_s] + 2'd1;
                end
            end else if (r_hit_s) begin
                ent_we_s = 1'b1;
                if (ctr_q[r_idx_s] == 2'd0) begin
                    ent_ctr_d = 2'd0;
                end else begin
                    ent_ctr_d = ctr_q[r_idx_s] - 2'd1;
                end
            end else begin
                ent_we_s = 1'b0;
            end
        end else begin
            ent_we_s = 1'b0;
        end
    end

    // Saturating perf counters: they keep counting even while the table is cleared
    always_comb begin
        if (bus.i_res_valid && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end else begin
            br_count_d = br_count_q;
        end
        if (mispredict_s && (mp_count_q != 32'hFFFF_FFFF)) begin
            mp_count_d = mp_count_q + 32'd1;
        end else begin
            mp_count_d = mp_count_q;
        end
    end

    // BTB storage; a miss that allocates overwrites whatever lived at that index
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd0;
            end
        end else if (bus.i_clear) begin
            valid_q <= '0;
        end else if (ent_we_s) begin
            valid_q[r_idx_s]  <= 1'b1;
            tag_q[r_idx_s]    <= r_tag_s;
            target_q[r_idx_s] <= ent_target_d;
            ctr_q[r_idx_s]    <= ent_ctr_d;
        end
    end

    // Perf counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_count_q <= 32'd0;
            mp_count_q <= 32'd0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign bus.o_br_count = br_count_q;
    assign bus.o_mp_count = mp_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table-level reference model predicts every
// cycle's outputs, the driver queues them and a negedge monitor compares.
module tb_branch_predictor;
    localparam int ENT = 16;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    bp_if #(.WIDTH(32)) bus ();

    branch_predictor #(.WIDTH(32), .ENTRIES(ENT)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit          pt;
        logic [31:0] ptgt;
        bit          mp;
        logic [31:0] rdr;
        logic [31:0] br;
        logic [31:0] mpc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          m_valid[ENT];
    int unsigned m_tag[ENT];
    int unsigned m_tgt[ENT];
    int          m_ctr[ENT];
    int unsigned m_br, m_mp;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_br = 0; m_mp = 0;
    endfunction

    function automatic bit m_hit(int unsigned pc);
        int unsigned idx = (pc / 4) % ENT;
        return m_valid[idx] && (m_tag[idx] == pc / (4 * ENT));
    endfunction

    function automatic bit m_pred_taken(int unsigned pc);
        return m_hit(pc) && (m_ctr[(pc / 4) % ENT] >= 2);
    endfunction

    function automatic int unsigned m_pred_target(int unsigned pc);
        return m_pred_taken(pc) ? m_tgt[(pc / 4) % ENT] : pc + 4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    endtask

    // Monitor: every queued expectation is compared mid-cycle
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_taken",  {31'd0, bus.o_pred_taken}, {31'd0, e.pt});
            chk("pred_target", bus.o_pred_target, e.ptgt);
            chk("mispredict",  {31'd0, bus.o_mispredict}, {31'd0, e.mp});
            chk("redirect_pc", bus.o_redirect_pc, e.rdr);
            chk("br_count",    bus.o_br_count, e.br);
            chk("mp_count",    bus.o_mp_count, e.mpc);
        end
    end

    // Drive one cycle, queue its expected outputs and advance the model past the edge
    task automatic issue(int unsigned fpc, bit vld, bit jump, bit jalr, bit cond,
                         int unsigned pc, int unsigned off, int unsigned rs1,
                         bit ptk, int unsigned ptg, bit clr, bit in_reset);
        exp_t e;
        bit taken, mp, hit;
        int unsigned tgt, idx;
        bus.i_fetch_pc = fpc;       bus.i_res_valid = vld;
        bus.i_res_is_jump = jump;   bus.i_res_is_jalr = jalr;
        bus.i_res_cond = cond;      bus.i_res_pc = pc;
        bus.i_res_offset = off;     bus.i_res_rs1 = rs1;
        bus.i_res_pred_taken = ptk; bus.i_res_pred_target = ptg;
        bus.i_clear = clr;
        taken = jump | cond;
        tgt   = jalr ? ((rs1 + off) & 32'hFFFF_FFFE) : (pc + off);
        mp    = !in_reset && vld && ((ptk != taken) || (taken && ptg != tgt));
        e.pt   = m_pred_taken(fpc);
        e.ptgt = m_pred_target(fpc);
        e.mp   = mp;
        e.rdr  = taken ? tgt : pc + 4;
        e.br   = m_br;
        e.mpc  = m_mp;
        exp_q.push_back(e);
        if (!in_reset) begin
            idx = (pc / 4) % ENT;
            hit = m_hit(pc);
            if (vld && m_br != 32'hFFFF_FFFF) m_br++;
            if (mp && m_mp != 32'hFFFF_FFFF) m_mp++;
            if (clr) begin
                for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
            end else if (vld && taken) begin
                if (!hit) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = pc / (4 * ENT);
                    m_ctr[idx]   = jump ? 3 : 2;
                end else begin
                    m_ctr[idx] = jump ? 3 : ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3);
                end
                m_tgt[idx] = tgt;
            end else if (vld && hit) begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic fetch_only(int unsigned fpc);
        issue(fpc, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    // Conditional branch with the model's own prediction carried down the pipe
    task automatic branch_fb(int unsigned pc, int unsigned off, bit cond);
        issue(pc, 1, 0, 0, cond, pc, off, 32'h0, m_pred_taken(pc), m_pred_target(pc), 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pcs[8] = '{32'h100, 32'h140, 32'h200, 32'h204,
                                32'h300, 32'h1300, 32'h2002, 32'h400};
        bus.i_fetch_pc = 32'h100; bus.i_clear = 1'b0; bus.i_res_valid = 1'b0;
        bus.i_res_is_jump = 1'b0; bus.i_res_is_jalr = 1'b0; bus.i_res_cond = 1'b0;
        bus.i_res_pc = 32'h0; bus.i_res_offset = 32'h0; bus.i_res_rs1 = 32'h0;
        bus.i_res_pred_taken = 1'b0; bus.i_res_pred_target = 32'h0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        fetch_only(32'h100);
        // JAL at 0x100 unpredicted, then predicted taken to 0x140
        issue(32'h100, 1, 1, 0, 0, 32'h100, 32'h40, 32'h0, 0, 32'h0, 0, 0);
        fetch_only(32'h100);
        // JALR bit-0 clearing
        issue(32'h300, 1, 1, 1, 0, 32'h300, 32'h4, 32'h2001, 0, 32'h0, 0, 0);
        issue(32'h300, 1, 1, 1, 0, 32'h300, 32'h4, 32'h2003,
              m_pred_taken(32'h300), m_pred_target(32'h300), 0, 0);
        fetch_only(32'h300);
        // counter walk at 0x200: T,T,N,N,N
        branch_fb(32'h200, 32'h80, 1);
        branch_fb(32'h200, 32'h80, 1);
        branch_fb(32'h200, 32'h80, 0);
        branch_fb(32'h200, 32'h80, 0);
        branch_fb(32'h200, 32'h80, 0);
        fetch_only(32'h200);
        // aliasing: 0x100 + 4*ENT replaces the 0x100 entry
        issue(32'h140, 1, 0, 0, 1, 32'h100 + 4 * ENT, 32'h8, 32'h0, 0, 32'h0, 0, 0);
        fetch_only(32'h100);
        fetch_only(32'h100 + 4 * ENT);
        // clear together with a taken resolve
        issue(32'h400, 1, 0, 0, 1, 32'h400, 32'h20, 32'h0, 0, 32'h0, 1, 0);
        fetch_only(32'h400);
        fetch_only(32'h100 + 4 * ENT);
        // branch counter saturation
        force dut.br_count_q = 32'hFFFF_FFFF;
        #1 release dut.br_count_q;
        m_br = 32'hFFFF_FFFF;
        issue(32'h400, 1, 0, 0, 0, 32'h400, 32'h20, 32'h0, 0, 32'h0, 0, 0);
        fetch_only(32'h400);

        // randomized traffic over a small, aliasing-prone PC set
        for (int n = 0; n < 300; n++) begin
            int unsigned fpc, pc, off, rs1, ptg;
            bit vld, jump, jalr, cond, ptk, clr;
            fpc  = pcs[$urandom_range(0, 7)];
            pc   = pcs[$urandom_range(0, 7)];
            vld  = ($urandom_range(0, 3) != 0);
            jump = ($urandom_range(0, 3) == 0);
            jalr = jump && $urandom_range(0, 1);
            cond = $urandom_range(0, 1);
            off  = $urandom_range(0, 1) ? $urandom_range(0, 255) * 4 : $urandom();
            rs1  = $urandom();
            clr  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) != 0) begin
                ptk = m_pred_taken(pc); ptg = m_pred_target(pc);
            end else begin
                ptk = $urandom_range(0, 1); ptg = $urandom();
            end
            issue(fpc, vld, jump, jalr, cond, pc, off, rs1, ptk, ptg, clr, 0);
        end

        // asynchronous reset mid-stream: training vanishes before any edge
        issue(32'h100, 1, 1, 0, 0, 32'h100, 32'h40, 32'h0, 0, 32'h0, 0, 0);
        i_rst_n = 1'b0;
        model_reset();
        issue(32'h100, 1, 1, 0, 0, 32'h100, 32'h40, 32'h0, 0, 32'h0, 0, 1);
        i_rst_n = 1'b1;
        fetch_only(32'h100);

        @(negedge i_clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
